// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, 8x oversampled baud clock,
// mid-bit sampling, framing-error / overrun / break handling.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_baud8_clk,
  input  logic       i_rx,
  input  logic       i_rd,
  output logic [7:0] o_data,
  output logic       o_rxne,
  output logic       o_fe,
  output logic       o_ore,
  output logic       o_bsy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] rx_sync;
  logic [SYNC_STAGES-1:0] baud_sync;
  logic                   baud_prev;
  logic                   rx_s;
  logic                   baud_s;
  logic                   tick;

  logic [2:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;

  logic cnt_clr;
  logic cnt_inc;
  logic idx_clr;
  logic shift_en;
  logic done;
  logic fe_set;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_sync   <= '1;
      baud_sync <= '0;
      baud_prev <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[SYNC_STAGES-2:0], i_rx};
      baud_sync <= {baud_sync[SYNC_STAGES-2:0], i_baud8_clk};
      baud_prev <= baud_s;
    end
  end

  assign rx_s   = rx_sync[SYNC_STAGES-1];
  assign baud_s = baud_sync[SYNC_STAGES-1];
  assign tick   = baud_s & ~baud_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) state_nxt = START;
        end
        START: begin
          if (cnt == 3'd3) state_nxt = rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (cnt == 3'd7 && idx == 3'd7) state_nxt = STOP;
        end
        STOP: begin
          if (cnt == 3'd7) state_nxt = rx_s ? IDLE : BREAK;
        end
        BREAK: begin
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    idx_clr  = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    fe_set   = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: cnt_clr = 1'b1;
        START: begin
          if (cnt == 3'd3) begin
            cnt_clr = 1'b1;
            idx_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        DATA: begin
          cnt_inc  = 1'b1;
          shift_en = (cnt == 3'd7);
        end
        STOP: begin
          cnt_inc = 1'b1;
          done    = (cnt == 3'd7) & rx_s;
          fe_set  = (cnt == 3'd7) & ~rx_s;
        end
        BREAK: ;
        default: ;
      endcase
    end
  end

  // Counter wraps 7->0 naturally, marking each bit boundary.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= 3'd0;
      idx   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      if (cnt_clr) begin
        cnt <= 3'd0;
      end else if (cnt_inc) begin
        cnt <= cnt + 3'd1;
      end
      if (idx_clr) begin
        idx <= 3'd0;
      end else if (shift_en) begin
        idx <= idx + 3'd1;
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[7:1]};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data <= 8'h00;
      o_rxne <= 1'b0;
      o_fe   <= 1'b0;
      o_ore  <= 1'b0;
      o_bsy  <= 1'b0;
    end else begin
      o_fe  <= fe_set;
      o_ore <= done & o_rxne & ~i_rd;
      o_bsy <= (state != IDLE);
      if (done) begin
        if (!o_rxne || i_rd) begin
          o_data <= shreg;
          o_rxne <= 1'b1;
        end
      end else if (i_rd) begin
        o_rxne <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random
// frames checked against a frame-level receive model.
module tb_uart_rx;

  localparam int SYNC = 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       baud8 = 1'b0;
  logic       rx    = 1'b1;
  logic       rd    = 1'b0;
  logic [7:0] data;
  logic       rxne;
  logic       fe;
  logic       ore;
  logic       bsy;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ore_cnt  = 0;

  uart_rx #(.SYNC_STAGES(SYNC)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_baud8_clk(baud8),
    .i_rx       (rx),
    .i_rd       (rd),
    .o_data     (data),
    .o_rxne     (rxne),
    .o_fe       (fe),
    .o_ore      (ore),
    .o_bsy      (bsy)
  );

  always #5 clk = ~clk;

  // Baud x8 clock: 8 clk cycles per period.
  initial begin
    forever begin
      repeat (4) @(negedge clk);
      baud8 = ~baud8;
    end
  end

  always @(negedge clk) begin
    if (fe)  fe_cnt++;
    if (ore) ore_cnt++;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic read_pulse();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: plain, 1: rd on completion cycle,
  // 2: latency check on rxne, 3: reset during data bit 4
  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input int mode);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge baud8);
      rx = fr[i];
      if (i == 9 && mode == 1) begin
        repeat (4) @(posedge baud8);
        repeat (SYNC) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        repeat (3) @(posedge baud8);
      end else if (i == 9 && mode == 2) begin
        repeat (4) @(posedge baud8);
        repeat (SYNC) @(negedge clk);
        n_checks++;
        if (rxne !== 1'b0) begin
          n_fail++;
          $display("FAIL lat_early: rxne=%b want 0", rxne);
        end
        @(negedge clk);
        n_checks++;
        if (rxne !== 1'b1) begin
          n_fail++;
          $display("FAIL lat_rise: rxne=%b want 1", rxne);
        end
        repeat (3) @(posedge baud8);
      end else if (i == 5 && mode == 3) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({data, rxne, fe, ore, bsy} !== 12'h000) begin
          n_fail++;
          $display("FAIL rst_mid: got %h/%b%b%b%b want 00/0000",
                   data, rxne, fe, ore, bsy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (7) @(posedge baud8);
      end else begin
        repeat (7) @(posedge baud8);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({data, rxne, fe, ore, bsy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset: got %h/%b%b%b%b want 00/0000",
               data, rxne, fe, ore, bsy);
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int f0;
    int o0;
    f0 = fe_cnt;
    o0 = ore_cnt;
    send_frame(8'h55, 1'b1, 2);
    repeat (2) @(negedge clk);
    n_checks++;
    if (data !== 8'h55 || rxne !== 1'b1) begin
      n_fail++;
      $display("FAIL single: data=%h rxne=%b want 55/1", data, rxne);
    end
    n_checks++;
    if (fe_cnt != f0 || ore_cnt != o0) begin
      n_fail++;
      $display("FAIL single_flags: fe=%0d ore=%0d want %0d/%0d",
               fe_cnt, ore_cnt, f0, o0);
    end
    read_pulse();
    n_checks++;
    if (rxne !== 1'b0 || data !== 8'h55) begin
      n_fail++;
      $display("FAIL read: data=%h rxne=%b want 55/0", data, rxne);
    end
    read_pulse();
    n_checks++;
    if (rxne !== 1'b0 || data !== 8'h55) begin
      n_fail++;
      $display("FAIL read_empty: data=%h rxne=%b want 55/0",
               data, rxne);
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    o0 = ore_cnt;
    send_frame(8'hA3, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (data !== 8'hA3 || rxne !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b: data=%h rxne=%b want a3/1", data, rxne);
    end
    n_checks++;
    if (ore_cnt - o0 != 1) begin
      n_fail++;
      $display("FAIL b2b_ore: pulses=%0d want 1", ore_cnt - o0);
    end
    read_pulse();
    n_checks++;
    if (rxne !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_read: rxne=%b want 0", rxne);
    end
  endtask

  task automatic test_break();
    int f0;
    f0 = fe_cnt;
    send_frame(8'hF0, 1'b0, 0);
    repeat (160) @(posedge baud8);
    @(negedge clk);
    n_checks++;
    if (fe_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL brk_fe: pulses=%0d want 1", fe_cnt - f0);
    end
    n_checks++;
    if (bsy !== 1'b1 || rxne !== 1'b0) begin
      n_fail++;
      $display("FAIL brk_hold: bsy=%b rxne=%b want 1/0", bsy, rxne);
    end
    @(posedge baud8);
    rx = 1'b1;
    repeat (3) @(posedge baud8);
    @(negedge clk);
    n_checks++;
    if (bsy !== 1'b0 || rxne !== 1'b0 || fe_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL brk_end: bsy=%b rxne=%b fe=%0d want 0/0/1",
               bsy, rxne, fe_cnt - f0);
    end
  endtask

  task automatic test_glitch();
    int f0;
    int o0;
    f0 = fe_cnt;
    o0 = ore_cnt;
    @(posedge baud8);
    rx = 1'b0;
    repeat (2) @(posedge baud8);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bsy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_start: bsy=%b want 1", bsy);
    end
    repeat (10) @(posedge baud8);
    @(negedge clk);
    n_checks++;
    if (bsy !== 1'b0 || rxne !== 1'b0 ||
        fe_cnt != f0 || ore_cnt != o0) begin
      n_fail++;
      $display("FAIL glitch: bsy=%b rxne=%b fe=%0d ore=%0d want 0/0",
               bsy, rxne, fe_cnt - f0, ore_cnt - o0);
    end
  endtask

  task automatic test_rd_collide();
    int o0;
    send_frame(8'h7E, 1'b1, 0);
    @(negedge clk);
    n_checks++;
    if (data !== 8'h7E || rxne !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_first: data=%h rxne=%b want 7e/1",
               data, rxne);
    end
    o0 = ore_cnt;
    send_frame(8'h81, 1'b1, 1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (data !== 8'h81 || rxne !== 1'b1 || ore_cnt != o0) begin
      n_fail++;
      $display("FAIL coll: data=%h rxne=%b ore=%0d want 81/1/0",
               data, rxne, ore_cnt - o0);
    end
  endtask

  task automatic test_reset_midframe();
    int f0;
    int o0;
    send_frame(8'hFF, 1'b1, 3);
    f0 = fe_cnt;
    o0 = ore_cnt;
    send_frame(8'h12, 1'b1, 0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (data !== 8'h12 || rxne !== 1'b1 ||
        fe_cnt != f0 || ore_cnt != o0) begin
      n_fail++;
      $display("FAIL rst_resume: data=%h rxne=%b fe=%0d ore=%0d want 12/1",
               data, rxne, fe_cnt - f0, ore_cnt - o0);
    end
  endtask

  task automatic test_random();
    logic [7:0] m_data;
    logic       m_rxne;
    int         m_ore;
    logic [7:0] b;
    read_pulse();
    m_data = data;
    m_rxne = 1'b0;
    m_ore  = ore_cnt;
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 20)) @(posedge baud8);
      send_frame(b, 1'b1, 0);
      repeat (2) @(negedge clk);
      if (!m_rxne) begin
        m_data = b;
        m_rxne = 1'b1;
      end else begin
        m_ore++;
      end
      n_checks++;
      if (data !== m_data || rxne !== m_rxne || ore_cnt != m_ore) begin
        n_fail++;
        $display("FAIL rand%0d: data=%h rxne=%b ore=%0d want %h/%b/%0d",
                 k, data, rxne, ore_cnt, m_data, m_rxne, m_ore);
      end
      if ($urandom_range(0, 1) == 1) begin
        read_pulse();
        m_rxne = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_break();
    test_glitch();
    test_rd_collide();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flop stages on i_rx and on i_baud8_clk (allowed: 2 or 3).
REQ-002 SHALL have port i_clk  input  1  system clock; every flop is clocked on the rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port i_baud8_clk  input  1  baud clock x8; same source as the transmitter's baud clock.
REQ-005 SHALL have port i_rx  input  1  UART RX pin; asynchronous; idles high.
REQ-006 SHALL have port i_rd  input  1  read strobe; one i_clk cycle; acknowledges o_data.
REQ-007 SHALL have port o_data  output  8  last good received byte.
REQ-008 SHALL have port o_rxne  output  1  RX not-empty flag; o_data is valid while it is 1.
REQ-009 SHALL have port o_fe  output  1  framing-error strobe; 1 cycle.
REQ-010 SHALL have port o_ore  output  1  overrun strobe; 1 cycle.
REQ-011 SHALL have port o_bsy  output  1  a frame is in progress (state is not IDLE).

Function
REQ-012 SHALL pass i_rx and i_baud8_clk through SYNC_STAGES synchronizer flops each; synchronized i_rx = rx_s.
REQ-013 SHALL produce tick, a 1-cycle pulse on each 0->1 transition of the synchronized i_baud8_clk; 8 ticks = 1 bit time.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK, plus a 3-bit tick counter and a 3-bit bit index.
REQ-015 IDLE: on tick with rx_s=0 -> START; counter cleared to 0.
REQ-016 START: increment counter per tick; on the tick where counter=3 (mid-bit), sample rx_s.
- rx_s=1: false start -> IDLE; no flags.
- rx_s=0: -> DATA; counter=0; bit index=0.
REQ-017 DATA: on every 8th tick (counter wraps 7->0), shift rx_s into a shift register, LSB first; after bit index 7 -> STOP.
REQ-018 STOP: sample rx_s on the 8th tick after the last data sample.
- rx_s=1: byte complete -> IDLE.
- rx_s=0: o_fe=1 for 1 cycle; byte discarded -> BREAK.
REQ-019 BREAK: remain until a tick with rx_s=1 -> IDLE; a held-low line SHALL NOT produce further frames or o_fe pulses.
REQ-020 Byte complete with o_rxne=0, or with o_rxne=1 and i_rd=1 in the same cycle: o_data <= shift register; o_rxne=1 on the next cycle; o_ore=0.
REQ-021 Byte complete with o_rxne=1 and i_rd=0: o_ore=1 for 1 cycle; new byte discarded; o_data and o_rxne unchanged.
REQ-022 i_rd=1 with no byte completing: o_rxne=0 on the next cycle; o_data held.
REQ-023 i_rd=1 while o_rxne=0: no effect.
REQ-024 o_bsy SHALL be registered and equal to (state != IDLE), delayed 1 cycle.
REQ-025 Latency: o_rxne rises exactly 1 i_clk cycle after the tick that samples a valid stop bit.
REQ-026 i_rx transitions between ticks SHALL be ignored; sampling happens only on ticks.

Reset
REQ-027 On i_rst=1, immediately and regardless of i_clk:
- o_data=8'h00; o_rxne=0; o_fe=0; o_ore=0; o_bsy=0.
- state=IDLE; counter=0; bit index=0; shift register=0.
- synchronizers=1 for i_rx and 0 for i_baud8_clk.
REQ-028 Reset mid-frame SHALL abort the frame with no flags set; after release, reception resumes at the next falling edge seen in IDLE.

Verification
REQ-029 Frame 0x55 (start, 1,0,1,0,1,0,1,0, stop=1) -> o_data=8'h55, o_rxne=1, o_fe=0, o_ore=0.
REQ-030 Back-to-back 0xA3 then 0x3C with no i_rd -> o_data=8'hA3, o_ore pulses once at end of the second frame, o_rxne stays 1; then i_rd -> o_rxne=0.
REQ-031 Frame 0xF0 with stop=0, then line held low for 20 bit times -> exactly one o_fe pulse, o_rxne=0, o_bsy=1 until the line returns high.
REQ-032 Low glitch of 2 ticks in IDLE -> returns to IDLE at the mid-start sample; no o_rxne/o_fe/o_ore.
REQ-033 i_rd asserted in the same cycle a second byte 0x81 completes (o_rxne=1 holding 0x7E) -> o_data=8'h81, o_rxne=1, o_ore=0.
REQ-034 i_rst pulsed at data bit 4 of frame 0xFF, then frame 0x12 sent -> all outputs 0 during reset; then o_data=8'h12, no error flags.
